// File: rtl/fifo_pkg.sv
// Shared sizing helpers and parameter legality check for the stream FIFO family.
package fifo_pkg;

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic bit params_ok(input int depth, input int ae_th, input int af_th);
        return (depth >= 2) && (ae_th < af_th) && (af_th <= depth);
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Read/write pointer for the stream FIFO: increments on enable, wraps DEPTH-1 -> 0.
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     en_i,
    output logic [ptr_w(DEPTH)-1:0]  ptr_o
);

    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    // Explicit compare keeps non-power-of-two depths from stepping into unused slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_o <= '0;
        end else if (clr_i) begin
            ptr_o <= '0;
        end else if (en_i) begin
            ptr_o <= (ptr_o == LAST) ? '0 : ptr_o + PW'(1);
        end
    end

endmodule

// File: rtl/stream_fifo.sv
// Synchronous valid/ready FIFO with FWFT or registered-pop output, fill level,
// almost-full/empty thresholds, synchronous flush and sticky overflow/underflow.
module stream_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 32,
    parameter int FWFT       = 1,
    parameter int AF_TH      = DEPTH - 2,
    parameter int AE_TH      = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [DATA_WIDTH-1:0]    in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DATA_WIDTH-1:0]    out_data_o,
    output logic [lvl_w(DEPTH)-1:0]  level_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     almost_full_o,
    output logic                     almost_empty_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    localparam int PW = ptr_w(DEPTH);
    localparam int LW = lvl_w(DEPTH);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AF   = LW'(AF_TH);
    localparam logic [LW-1:0] LVL_AE   = LW'(AE_TH);

    if (!params_ok(DEPTH, AE_TH, AF_TH)) begin : g_param_check
        $error("stream_fifo: need DEPTH >= 2 and AE_TH < AF_TH <= DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [LW-1:0]         level_q;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  overflow_q;
    logic                  underflow_q;

    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);

    // Flush wins over both sides; gating here keeps level and pointers consistent.
    assign push = in_valid_i && !full && !flush_i;
    assign pop  = out_ready_i && !empty && !flush_i;

    assign in_ready_o     = !full;
    assign level_o        = level_q;
    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (level_q >= LVL_AF);
    assign almost_empty_o = (level_q <= LVL_AE);
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (flush_i),
        .en_i  (push),
        .ptr_o (wptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (flush_i),
        .en_i  (pop),
        .ptr_o (rptr)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
        end else if (flush_i) begin
            level_q <= '0;
        end else if (push && !pop) begin
            level_q <= level_q + LW'(1);
        end else if (pop && !push) begin
            level_q <= level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flush_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (in_valid_i && full) begin
                overflow_q <= 1'b1;
            end
            if ((FWFT == 0) && out_ready_i && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign out_valid_o = !empty;
        assign out_data_o  = empty ? '0 : mem[rptr];
    end else begin : g_reg_pop
        logic                  valid_q;
        logic [DATA_WIDTH-1:0] data_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (flush_i) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= pop;
                data_q  <= pop ? mem[rptr] : '0;
            end
        end

        assign out_valid_o = valid_q;
        assign out_data_o  = data_q;
    end

endmodule

// File: doc/stream_fifo.md
# stream_fifo

Parametrised synchronous FIFO with valid/ready handshakes on both sides. It is the successor to the single-mode FIFO in the AES datapath and buffers 128-bit blocks between key/data ingress and the cipher cores. It adds:
- selectable first-word-fall-through (FWFT) or registered-pop mode,
- arbitrary (non-power-of-two) depth,
- programmable almost-full/almost-empty thresholds,
- a fill-level output, a synchronous flush, and sticky error flags.

## Interface
Parameters:
- DATA_WIDTH, 128, payload width in bits
- DEPTH, 32, number of entries; any integer ≥ 2
- FWFT, 1, 1 = head word visible at output; 0 = registered pop (data one cycle after request)
- AF_TH, DEPTH-2, almost_full_o asserts when level ≥ AF_TH
- AE_TH, 2, almost_empty_o asserts when level ≤ AE_TH

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous clear of contents and error flags
- in_valid_i  in  1  write request
- in_ready_o  out  1  write accepted when in_valid_i && in_ready_o
- in_data_i  in  DATA_WIDTH  write data
- out_valid_o  out  1  output word valid
- out_ready_i  in  1  FWFT=1: consumer accepts; FWFT=0: pop request
- out_data_o  out  DATA_WIDTH  output data; all zero whenever out_valid_o = 0
- level_o  out  $clog2(DEPTH+1)  current entry count
- full_o, empty_o, almost_full_o, almost_empty_o  out  1 each  status flags, all derived from level
- overflow_o  out  1  sticky: write attempted while full
- underflow_o  out  1  sticky: FWFT=0 pop requested while empty

## Operation
- **Push** = in_valid_i && !full. Write to mem[wptr]; wptr advances with explicit wrap DEPTH-1 → 0.
- **in_ready_o** = !full. It does not depend on out_ready_i, so there is no combinational path through the FIFO. A push with a simultaneous pop while full is refused and sets overflow_o.
- **Pop, FWFT=1**
  - out_valid_o = !empty; out_data_o = mem[rptr].
  - Pop = out_valid_o && out_ready_i.
  - A word pushed into an empty FIFO becomes visible the cycle after the push.
- **Pop, FWFT=0**
  - Pop = out_ready_i && !empty.
  - On the next cycle out_valid_o = 1 and out_data_o = the popped word for exactly one cycle; otherwise out_data_o = 0.
  - out_ready_i while empty sets underflow_o. No pop occurs and no output is produced.
- **Level update**: push only → +1; pop only → −1; both or neither → unchanged. level never exceeds DEPTH and never wraps below 0.
- **Flush**
  - Takes priority over push and pop in the same cycle.
  - Next cycle: wptr = rptr = level = 0 and overflow_o = underflow_o = 0. The FWFT=0 output register is cleared.
  - Memory contents are not cleared.
- **Sticky flags** clear only on flush or reset.
- **Storage array** is not reset. Pointers, level, output register and flags are reset.

## Timing
- **Reset values**: in_ready_o = 1, out_valid_o = 0, out_data_o = 0, level_o = 0, empty_o = 1, almost_empty_o = 1, full_o = 0, almost_full_o = 0 (given AF_TH > 0), overflow_o = 0, underflow_o = 0.
- **Reset asserted mid-transfer**: all of the above take effect immediately (asynchronously). Data in flight is discarded.
- **Latency**:
  - FWFT=1: write to output-visible = 1 cycle.
  - FWFT=0: pop request to data = 1 cycle.
- **Status flags** are functions of registered level, so they update the cycle after the causing push, pop or flush.
- **Throughput**: one push and one pop per cycle sustained, including across pointer wrap for non-power-of-two DEPTH.

## Structure
- Package fifo_pkg holds:
  - the level-width function lvl_w(depth) = $clog2(depth+1),
  - the pointer-width function ptr_w(depth) = $clog2(depth),
  - a parameter-check macro or elaboration assertion: DEPTH ≥ 2, AE_TH < AF_TH ≤ DEPTH.
- Sub-module fifo_wrap_ptr: a parametrised pointer with enable, synchronous clear and wrap at DEPTH-1. It is instantiated for wptr and rptr.
- Storage stays inline as an unreset array so synthesis can infer RAM.

## Test plan
- **Fill and drain**, DEPTH=5, FWFT=1:
  - Push 0x1..0x5 with out_ready_i = 0 → full_o = 1, in_ready_o = 0, level_o = 5, almost_full_o = 1 from level 3.
  - Drain → out_data_o sequence 0x1..0x5, then empty_o = 1.
- **Wrap at non-power-of-two depth**, DEPTH=5, FWFT=1: stream 40 incrementing words with both sides always valid/ready → output is identical in order, with no gaps after the first word.
- **FWFT=0 legacy behaviour**, DEPTH=32:
  - Push 0xA, 0xB, then pulse out_ready_i twice → out_valid_o high on the two following cycles with 0xA then 0xB.
  - A third request → underflow_o = 1 and out_data_o = 0.
- **Overflow while full**, DEPTH=4: fill with 0x1..0x4, then drive push 0x9 and pop in the same cycle →
  - 0x9 is refused and overflow_o = 1,
  - level_o = 3 afterwards,
  - remaining output is 0x2, 0x3, 0x4.
- **Flush priority**, FWFT=1: with 3 entries, assert flush_i together with push and pop → next cycle level_o = 0, empty_o = 1, sticky flags = 0. A later push of 0x7 reads back 0x7.
- **Asynchronous reset** mid-stream: assert rst_n low between clock edges while level_o = 2 → all outputs immediately take their reset values, and resume correctly after release.
